// File: rtl/sparc_byte_ram_if.sv
// Memory bus between the SPARC datapath (MAR/MDR side) and the byte RAM.
// Signal names follow the datapath's register naming; the master drives requests.
interface sparc_byte_ram_if;
  logic        Enable;
  logic [3:0]  OpCode;
  logic [31:0] MAR_Address;
  logic [31:0] MDR_DataIn;
  logic [31:0] MDR_DataOut;
  logic        MFC;
  logic        Misaligned;

  // Request accepted on every rising clk edge where Enable=1 (no back-pressure);
  // MFC pulses for exactly the one cycle that follows each accepted request.
  modport master (
    output Enable, OpCode, MAR_Address, MDR_DataIn,
    input  MDR_DataOut, MFC, Misaligned
  );

  modport slave (
    input  Enable, OpCode, MAR_Address, MDR_DataIn,
    output MDR_DataOut, MFC, Misaligned
  );
endinterface

// File: rtl/sparc_byte_ram.sv
// Big-endian byte-addressed data RAM with byte/half/word loads and stores.
// The array is not initialised; contents are X until written.
module sparc_byte_ram #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  sparc_byte_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic                  is_write, is_signed;
  logic [1:0]            size;
  logic                  misaligned;
  logic                  do_write, do_read;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           rdata;
  logic [31:0]           dout_d, dout_q;
  logic                  mfc_d, mfc_q;
  logic                  mis_d, mis_q;
  logic                  unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap within the array.
  assign unused_addr_bits = ^bus.MAR_Address[31:ADDR_WIDTH];

  always_comb begin
    a0        = bus.MAR_Address[ADDR_WIDTH-1:0];
    a1        = a0 + ADDR_WIDTH'(1);
    a2        = a0 + ADDR_WIDTH'(2);
    a3        = a0 + ADDR_WIDTH'(3);
    is_write  = bus.OpCode[3];
    is_signed = bus.OpCode[2];
    size      = bus.OpCode[1:0];
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a0[0];
      default: misaligned = |a0[1:0];
    endcase
    do_write = reset_n & bus.Enable & is_write & ~misaligned;
    do_read  = bus.Enable & ~is_write & ~misaligned;
  end

  // Lowest address carries the most significant byte.
  always_comb begin
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (size)
      2'b00:   rdata = {{24{is_signed & b0[7]}}, b0};
      2'b01:   rdata = {{16{is_signed & b0[7]}}, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      case (size)
        2'b00: mem[a0] <= bus.MDR_DataIn[7:0];
        2'b01: begin
          mem[a0] <= bus.MDR_DataIn[15:8];
          mem[a1] <= bus.MDR_DataIn[7:0];
        end
        default: begin
          mem[a0] <= bus.MDR_DataIn[31:24];
          mem[a1] <= bus.MDR_DataIn[23:16];
          mem[a2] <= bus.MDR_DataIn[15:8];
          mem[a3] <= bus.MDR_DataIn[7:0];
        end
      endcase
    end
  end

  always_comb begin
    dout_d = do_read ? rdata : dout_q;
    mfc_d  = bus.Enable;
    mis_d  = bus.Enable & misaligned;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 32'h0;
      mfc_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      mfc_q  <= mfc_d;
      mis_q  <= mis_d;
    end
  end

  assign bus.MDR_DataOut = dout_q;
  assign bus.MFC         = mfc_q;
  assign bus.Misaligned  = mis_q;

endmodule

// File: tb/tb_sparc_byte_ram.sv
// Directed bench for sparc_byte_ram: round trips, endianness, extension,
// alignment, address wrap, back-to-back traffic and asynchronous reset.
module tb_sparc_byte_ram;

  localparam logic [3:0] OP_RD_UB = 4'b0000;
  localparam logic [3:0] OP_RD_UH = 4'b0001;
  localparam logic [3:0] OP_RD_W  = 4'b0010;
  localparam logic [3:0] OP_RD_W3 = 4'b0011;
  localparam logic [3:0] OP_RD_SB = 4'b0100;
  localparam logic [3:0] OP_RD_SH = 4'b0101;
  localparam logic [3:0] OP_RD_SW = 4'b0110;
  localparam logic [3:0] OP_WR_B  = 4'b1000;
  localparam logic [3:0] OP_WR_H  = 4'b1001;
  localparam logic [3:0] OP_WR_W  = 4'b1010;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] dout_s;
  logic        mfc_s;
  logic        mis_s;

  sparc_byte_ram_if bus ();

  sparc_byte_ram #(.ADDR_WIDTH(9)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drive one request at the falling edge, then sample just after the rising edge.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.Enable      = 1'b1;
    bus.OpCode      = op;
    bus.MAR_Address = addr;
    bus.MDR_DataIn  = data;
    @(posedge clk);
    #1;
    dout_s = bus.MDR_DataOut;
    mfc_s  = bus.MFC;
    mis_s  = bus.Misaligned;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.Enable = 1'b0;
    @(posedge clk);
    #1;
    dout_s = bus.MDR_DataOut;
    mfc_s  = bus.MFC;
    mis_s  = bus.Misaligned;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n         = 1'b0;
    bus.Enable      = 1'b0;
    bus.OpCode      = 4'h0;
    bus.MAR_Address = 32'h0;
    bus.MDR_DataIn  = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.MDR_DataOut !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h want 00000000", bus.MDR_DataOut); end
    n_cmp++; if (bus.MFC !== 1'b0) begin n_err++; $display("FAIL rst_mfc: got %b want 0", bus.MFC); end
    n_cmp++; if (bus.Misaligned !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b want 0", bus.Misaligned); end
    reset_n = 1'b1;
    idle();
    n_cmp++; if (mfc_s !== 1'b0) begin n_err++; $display("FAIL rst_idle_mfc: got %b want 0", mfc_s); end
  endtask

  task automatic test_word_round_trip();
    access(OP_WR_W, 32'h010, 32'hDEADBEEF);
    n_cmp++; if (mfc_s !== 1'b1) begin n_err++; $display("FAIL wr_w_mfc: got %b want 1", mfc_s); end
    n_cmp++; if (mis_s !== 1'b0) begin n_err++; $display("FAIL wr_w_mis: got %b want 0", mis_s); end
    n_cmp++; if (dout_s !== 32'h0) begin n_err++; $display("FAIL wr_w_dout_hold: got %h want 00000000", dout_s); end
    idle();
    access(OP_RD_W, 32'h010, 32'h0);
    n_cmp++; if (dout_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_w: got %h want deadbeef", dout_s); end
    n_cmp++; if (mfc_s !== 1'b1) begin n_err++; $display("FAIL rd_w_mfc: got %b want 1", mfc_s); end
    idle();
    n_cmp++; if (mfc_s !== 1'b0) begin n_err++; $display("FAIL rd_w_mfc_pulse: got %b want 0", mfc_s); end
    n_cmp++; if (dout_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_hold: got %h want deadbeef", dout_s); end
  endtask

  task automatic test_byte_endian();
    access(OP_RD_UB, 32'h010, 32'h0);
    n_cmp++; if (dout_s !== 32'h000000DE) begin n_err++; $display("FAIL rd_ub10: got %h want 000000de", dout_s); end
    access(OP_RD_SB, 32'h013, 32'h0);
    n_cmp++; if (dout_s !== 32'hFFFFFFEF) begin n_err++; $display("FAIL rd_sb13: got %h want ffffffef", dout_s); end
    access(OP_RD_UB, 32'h011, 32'h0);
    n_cmp++; if (dout_s !== 32'h000000AD) begin n_err++; $display("FAIL rd_ub11: got %h want 000000ad", dout_s); end
    access(OP_RD_UH, 32'h012, 32'h0);
    n_cmp++; if (dout_s !== 32'h0000BEEF) begin n_err++; $display("FAIL rd_uh12: got %h want 0000beef", dout_s); end
    access(OP_RD_SW, 32'h010, 32'h0);
    n_cmp++; if (dout_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_sw: got %h want deadbeef", dout_s); end
    idle();
  endtask

  task automatic test_halfword();
    access(OP_WR_H, 32'h020, 32'h00008001);
    access(OP_RD_SH, 32'h020, 32'h0);
    n_cmp++; if (dout_s !== 32'hFFFF8001) begin n_err++; $display("FAIL rd_sh20: got %h want ffff8001", dout_s); end
    access(OP_RD_UH, 32'h020, 32'h0);
    n_cmp++; if (dout_s !== 32'h00008001) begin n_err++; $display("FAIL rd_uh20: got %h want 00008001", dout_s); end
    access(OP_RD_SB, 32'h021, 32'h0);
    n_cmp++; if (dout_s !== 32'h00000001) begin n_err++; $display("FAIL rd_sb21: got %h want 00000001", dout_s); end
    idle();
  endtask

  task automatic test_misaligned();
    access(OP_WR_W, 32'h030, 32'h11223344);
    idle();
    access(OP_RD_UB, 32'h030, 32'h0);
    access(OP_WR_W, 32'h031, 32'h12345678);
    n_cmp++; if (mfc_s !== 1'b1) begin n_err++; $display("FAIL mis_wr_mfc: got %b want 1", mfc_s); end
    n_cmp++; if (mis_s !== 1'b1) begin n_err++; $display("FAIL mis_wr_flag: got %b want 1", mis_s); end
    n_cmp++; if (dout_s !== 32'h00000011) begin n_err++; $display("FAIL mis_wr_hold: got %h want 00000011", dout_s); end
    access(OP_RD_W, 32'h030, 32'h0);
    n_cmp++; if (dout_s !== 32'h11223344) begin n_err++; $display("FAIL mis_prior: got %h want 11223344", dout_s); end
    n_cmp++; if (mis_s !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", mis_s); end
    access(OP_RD_UH, 32'h021, 32'h0);
    n_cmp++; if (mis_s !== 1'b1) begin n_err++; $display("FAIL mis_rd_h: got %b want 1", mis_s); end
    n_cmp++; if (dout_s !== 32'h11223344) begin n_err++; $display("FAIL mis_rd_hold: got %h want 11223344", dout_s); end
    access(OP_RD_W3, 32'h032, 32'h0);
    n_cmp++; if (mis_s !== 1'b1) begin n_err++; $display("FAIL mis_size3: got %b want 1", mis_s); end
    access(OP_RD_W3, 32'h030, 32'h0);
    n_cmp++; if (dout_s !== 32'h11223344) begin n_err++; $display("FAIL rd_size3: got %h want 11223344", dout_s); end
    idle();
    n_cmp++; if (mis_s !== 1'b0) begin n_err++; $display("FAIL mis_idle: got %b want 0", mis_s); end
  endtask

  task automatic test_wrap();
    access(OP_WR_W, 32'h00000204, 32'hCAFEF00D);
    idle();
    access(OP_RD_W, 32'h004, 32'h0);
    n_cmp++; if (dout_s !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_rd: got %h want cafef00d", dout_s); end
    access(OP_RD_UB, 32'hFFFFFE07, 32'h0);
    n_cmp++; if (dout_s !== 32'h0000000D) begin n_err++; $display("FAIL wrap_hi_rd: got %h want 0000000d", dout_s); end
    idle();
  endtask

  task automatic test_back_to_back();
    access(OP_WR_W, 32'h040, 32'h0BADCAFE);
    access(OP_RD_W, 32'h040, 32'h0);
    n_cmp++; if (dout_s !== 32'h0BADCAFE) begin n_err++; $display("FAIL b2b_raw: got %h want 0badcafe", dout_s); end
    n_cmp++; if (mfc_s !== 1'b1) begin n_err++; $display("FAIL b2b_mfc: got %b want 1", mfc_s); end
    access(OP_WR_B, 32'h041, 32'hFFFFFF7F);
    n_cmp++; if (dout_s !== 32'h0BADCAFE) begin n_err++; $display("FAIL b2b_wr_hold: got %h want 0badcafe", dout_s); end
    access(OP_RD_W, 32'h040, 32'h0);
    n_cmp++; if (dout_s !== 32'h0B7FCAFE) begin n_err++; $display("FAIL b2b_byte_merge: got %h want 0b7fcafe", dout_s); end
    idle();
    n_cmp++; if (mfc_s !== 1'b0) begin n_err++; $display("FAIL b2b_end_mfc: got %b want 0", mfc_s); end
  endtask

  task automatic test_reset_mid_access();
    access(OP_WR_W, 32'h050, 32'h55667788);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.MFC !== 1'b0) begin n_err++; $display("FAIL midrst_mfc: got %b want 0", bus.MFC); end
    n_cmp++; if (bus.Misaligned !== 1'b0) begin n_err++; $display("FAIL midrst_mis: got %b want 0", bus.Misaligned); end
    @(negedge clk);
    bus.Enable = 1'b0;
    reset_n    = 1'b1;
    access(OP_RD_W, 32'h050, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.MDR_DataOut !== 32'h0) begin n_err++; $display("FAIL midrst_dout: got %h want 00000000", bus.MDR_DataOut); end
    n_cmp++; if (dout_s !== 32'h55667788) begin n_err++; $display("FAIL midrst_kept: got %h want 55667788", dout_s); end
    @(negedge clk);
    bus.Enable = 1'b0;
    reset_n    = 1'b1;
    access(OP_RD_W, 32'h010, 32'h0);
    n_cmp++; if (dout_s !== 32'hDEADBEEF) begin n_err++; $display("FAIL midrst_mem: got %h want deadbeef", dout_s); end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_word_round_trip();
    test_byte_endian();
    test_halfword();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
